// File: rtl/mem_interconnect.sv
// Memory-bus interconnect from the picorv32 native port to NUM_SLAVES peripherals:
// registered base/mask decode, one request in flight, timeout watchdog, sticky error IRQ.
module mem_interconnect #(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = '0,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = '0,
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic [31:0]             mem_rdata,
    output logic [NUM_SLAVES-1:0]   s_valid,
    input  logic [NUM_SLAVES-1:0]   s_ready,
    output logic [4*NUM_SLAVES-1:0] s_wstrb,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic                    err_irq,
    input  logic                    err_clr,
    output logic [31:0]             err_addr,
    output logic                    err_kind,
    output logic [7:0]              err_count,
    output logic [1:0]              fsm_state
);
    // Handshake: the CPU holds mem_valid until a one-cycle mem_ready pulse; s_valid[sel]
    // mirrors mem_valid while ACTIVE and the transfer completes in the cycle s_ready[sel]=1.
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, ERR = 2'd2} state_t;

    state_t             state, next_state;
    logic [SEL_W-1:0]   sel, hit_idx;
    logic [TMR_W-1:0]   timer;
    logic               hit, sel_ready, take_sel, err_enter, err_timeout;
    logic [31:0]        sel_rdata;

    assign s_addr    = mem_addr;
    assign s_wdata   = mem_wdata;
    assign fsm_state = state;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        s_valid   = '0;
        s_wstrb   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
                if (state == ACTIVE) begin
                    s_valid[i]       = mem_valid;
                    s_wstrb[4*i +: 4] = mem_wstrb;
                end
            end
        end
    end

    always_comb begin
        next_state  = state;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        take_sel    = 1'b0;
        err_enter   = 1'b0;
        err_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (hit) begin
                        take_sel   = 1'b1;
                        next_state = ACTIVE;
                    end else begin
                        err_enter  = 1'b1;
                        next_state = ERR;
                    end
                end
            end
            ACTIVE: begin
                if (!mem_valid) begin
                    next_state = IDLE;
                end else if (sel_ready) begin
                    mem_ready  = 1'b1;
                    mem_rdata  = sel_rdata;
                    next_state = IDLE;
                end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    err_enter   = 1'b1;
                    err_timeout = 1'b1;
                    next_state  = ERR;
                end
            end
            ERR: begin
                mem_ready  = 1'b1;
                mem_rdata  = ERR_RDATA;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            sel   <= '0;
            timer <= '0;
        end else begin
            state <= next_state;
            if (take_sel) begin
                sel   <= hit_idx;
                timer <= '0;
            end else if (state == ACTIVE && next_state == ACTIVE) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // A new error outranks a simultaneous err_clr so no event is lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_irq   <= 1'b0;
            err_kind  <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (err_enter) begin
            err_irq  <= 1'b1;
            err_kind <= err_timeout;
            err_addr <= mem_addr;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else if (err_clr) begin
            err_irq  <= 1'b0;
            err_kind <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_interconnect.sv
// Directed bench for mem_interconnect: hit/wait-state/write/unmapped/timeout/err_clr/
// saturation/mid-transaction reset, plus a second instance with fully overlapping windows.
module tb_mem_interconnect;
    logic        clk, resetn, mem_valid, err_clr;
    logic        mem_ready, err_irq, err_kind;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, s_addr, s_wdata, err_addr;
    logic [3:0]  mem_wstrb;
    logic [2:0]  s_valid, s_ready;
    logic [11:0] s_wstrb;
    logic [95:0] s_rdata;
    logic [7:0]  err_count;
    logic [1:0]  fsm_state;

    logic        o_mem_ready, o_err_irq, o_err_kind;
    logic [31:0] o_mem_rdata, o_s_addr, o_s_wdata, o_err_addr;
    logic [1:0]  o_s_valid, o_fsm_state;
    logic [1:0]  o_s_ready;
    logic [7:0]  o_s_wstrb, o_err_count;
    logic [63:0] o_s_rdata;

    int n_vec = 0;
    int n_err = 0;

    // Slave0: 16 KiB at 0; slave1: 64 KiB at 0x0005_0000; slave2: 16 MiB at 0x0200_0000.
    mem_interconnect #(
        .NUM_SLAVES(3),
        .SLAVE_BASE({32'h0200_0000, 32'h0005_0000, 32'h0000_0000}),
        .SLAVE_MASK({32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_C000}),
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_addr(s_addr), .s_wdata(s_wdata), .err_irq(err_irq),
        .err_clr(err_clr), .err_addr(err_addr), .err_kind(err_kind),
        .err_count(err_count), .fsm_state(fsm_state)
    );

    // Both windows match everything: slave0 must always win.
    mem_interconnect #(
        .NUM_SLAVES(2),
        .SLAVE_BASE(64'h0),
        .SLAVE_MASK(64'h0),
        .TIMEOUT_CYCLES(4),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) ovl (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(o_mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(o_mem_rdata), .s_valid(o_s_valid), .s_ready(o_s_ready),
        .s_wstrb(o_s_wstrb), .s_rdata(o_s_rdata), .s_addr(o_s_addr), .s_wdata(o_s_wdata),
        .err_irq(o_err_irq), .err_clr(err_clr), .err_addr(o_err_addr),
        .err_kind(o_err_kind), .err_count(o_err_count), .fsm_state(o_fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wstrb = ws;
        mem_wdata = wd;
    endtask

    task automatic test_reset();
        resetn = 1'b0; mem_valid = 1'b0; err_clr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        s_ready = '0; s_rdata = '0;
        o_s_ready = 2'b11; o_s_rdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
        #12;
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", mem_ready); end
        n_vec++; if (s_valid !== 3'b000) begin n_err++; $display("FAIL rst_svalid got %b want 000", s_valid); end
        n_vec++; if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", mem_rdata); end
        n_vec++; if (err_irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", err_irq); end
        n_vec++; if (err_kind !== 1'b0) begin n_err++; $display("FAIL rst_kind got %b want 0", err_kind); end
        n_vec++; if (err_addr !== 32'h0) begin n_err++; $display("FAIL rst_eaddr got %h want 0", err_addr); end
        n_vec++; if (err_count !== 8'h0) begin n_err++; $display("FAIL rst_count got %h want 0", err_count); end
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", fsm_state); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_read_hit();
        step();
        drive(32'h0000_0010, 4'b0000, 32'h0);
        s_ready = 3'b001;
        s_rdata[31:0] = 32'h1234_5678;
        @(negedge clk);
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rd_c1_ready got %b want 0", mem_ready); end
        n_vec++; if (s_valid !== 3'b000) begin n_err++; $display("FAIL rd_c1_svalid got %b want 000", s_valid); end
        step();
        @(negedge clk);
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rd_c2_ready got %b want 1", mem_ready); end
        n_vec++; if (mem_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL rd_rdata got %h want 12345678", mem_rdata); end
        n_vec++; if (s_valid !== 3'b001) begin n_err++; $display("FAIL rd_svalid got %b want 001", s_valid); end
        n_vec++; if (s_wstrb !== 12'h000) begin n_err++; $display("FAIL rd_swstrb got %h want 000", s_wstrb); end
        n_vec++; if (o_s_valid !== 2'b01) begin n_err++; $display("FAIL ovl_svalid got %b want 01", o_s_valid); end
        n_vec++; if (o_mem_rdata !== 32'hA0A0_A0A0) begin n_err++; $display("FAIL ovl_rdata got %h want a0a0a0a0", o_mem_rdata); end
        step();
        mem_valid = 1'b0; s_ready = 3'b000;
        @(negedge clk);
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rd_after_ready got %b want 0", mem_ready); end
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL rd_after_state got %0d want 0", fsm_state); end
    endtask

    task automatic test_wait_states();
        step();
        drive(32'h0005_1000, 4'b0000, 32'h0);
        s_ready = 3'b101;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL ws_ready%0d got %b want 0", k, mem_ready); end
            n_vec++; if (s_valid !== 3'b010) begin n_err++; $display("FAIL ws_svalid%0d got %b want 010", k, s_valid); end
        end
        step();
        s_ready = 3'b111;
        s_rdata[63:32] = 32'hCAFE_0001;
        @(negedge clk);
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL ws_done got %b want 1", mem_ready); end
        n_vec++; if (mem_rdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL ws_rdata got %h want cafe0001", mem_rdata); end
        step();
        mem_valid = 1'b0; s_ready = 3'b000;
    endtask

    task automatic test_write();
        step();
        drive(32'h0005_0004, 4'b0011, 32'hA5A5_0F0F);
        s_ready = 3'b010;
        @(negedge clk);
        step();
        @(negedge clk);
        n_vec++; if (s_wstrb !== 12'h030) begin n_err++; $display("FAIL wr_swstrb got %h want 030", s_wstrb); end
        n_vec++; if (s_valid !== 3'b010) begin n_err++; $display("FAIL wr_svalid got %b want 010", s_valid); end
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready got %b want 1", mem_ready); end
        n_vec++; if (s_wdata !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL wr_wdata got %h want a5a50f0f", s_wdata); end
        n_vec++; if (s_addr !== 32'h0005_0004) begin n_err++; $display("FAIL wr_addr got %h want 00050004", s_addr); end
        step();
        mem_valid = 1'b0; s_ready = 3'b000;
        @(negedge clk);
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL wr_single_pulse got %b want 0", mem_ready); end
    endtask

    task automatic test_unmapped();
        step();
        drive(32'h1000_0000, 4'b0000, 32'h0);
        @(negedge clk);
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL um_c1_ready got %b want 0", mem_ready); end
        step();
        @(negedge clk);
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL um_ready got %b want 1", mem_ready); end
        n_vec++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL um_rdata got %h want deadbeef", mem_rdata); end
        n_vec++; if (s_valid !== 3'b000) begin n_err++; $display("FAIL um_svalid got %b want 000", s_valid); end
        n_vec++; if (fsm_state !== 2'd2) begin n_err++; $display("FAIL um_state got %0d want 2", fsm_state); end
        n_vec++; if (err_irq !== 1'b1) begin n_err++; $display("FAIL um_irq got %b want 1", err_irq); end
        n_vec++; if (err_kind !== 1'b0) begin n_err++; $display("FAIL um_kind got %b want 0", err_kind); end
        n_vec++; if (err_addr !== 32'h1000_0000) begin n_err++; $display("FAIL um_eaddr got %h want 10000000", err_addr); end
        n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL um_count got %0d want 1", err_count); end
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL um_after got %b want 0", mem_ready); end
        // Unmapped write must not strobe any slave.
        step();
        drive(32'h4000_0008, 4'b1111, 32'h1111_2222);
        @(negedge clk);
        step();
        @(negedge clk);
        n_vec++; if (s_wstrb !== 12'h000) begin n_err++; $display("FAIL umw_swstrb got %h want 000", s_wstrb); end
        n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL umw_count got %0d want 2", err_count); end
        n_vec++; if (err_addr !== 32'h4000_0008) begin n_err++; $display("FAIL umw_eaddr got %h want 40000008", err_addr); end
        step();
        mem_valid = 1'b0;
    endtask

    task automatic test_timeout();
        step();
        drive(32'h0200_0040, 4'b0000, 32'h0);
        s_ready = 3'b000;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge clk);
            n_vec++; if (s_valid !== 3'b100) begin n_err++; $display("FAIL to_svalid%0d got %b want 100", k, s_valid); end
            n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL to_ready%0d got %b want 0", k, mem_ready); end
        end
        step();
        @(negedge clk);
        n_vec++; if (s_valid !== 3'b000) begin n_err++; $display("FAIL to_err_svalid got %b want 000", s_valid); end
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL to_err_ready got %b want 1", mem_ready); end
        n_vec++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL to_rdata got %h want deadbeef", mem_rdata); end
        n_vec++; if (err_kind !== 1'b1) begin n_err++; $display("FAIL to_kind got %b want 1", err_kind); end
        n_vec++; if (err_addr !== 32'h0200_0040) begin n_err++; $display("FAIL to_eaddr got %h want 02000040", err_addr); end
        n_vec++; if (err_count !== 8'd3) begin n_err++; $display("FAIL to_count got %0d want 3", err_count); end
        step();
        mem_valid = 1'b0;
        s_ready = 3'b100;
        s_rdata[95:64] = 32'h7777_7777;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL to_late_ready%0d got %b want 0", k, mem_ready); end
            n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL to_late_state%0d got %0d want 0", k, fsm_state); end
            step();
        end
        s_ready = 3'b000;
    endtask

    task automatic test_err_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        n_vec++; if (err_irq !== 1'b0) begin n_err++; $display("FAIL clr_irq got %b want 0", err_irq); end
        n_vec++; if (err_kind !== 1'b0) begin n_err++; $display("FAIL clr_kind got %b want 0", err_kind); end
        n_vec++; if (err_addr !== 32'h0200_0040) begin n_err++; $display("FAIL clr_eaddr got %h want 02000040", err_addr); end
        n_vec++; if (err_count !== 8'd3) begin n_err++; $display("FAIL clr_count got %0d want 3", err_count); end
        step();
        drive(32'h3000_0000, 4'b0000, 32'h0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        n_vec++; if (err_irq !== 1'b1) begin n_err++; $display("FAIL clr_race_irq got %b want 1", err_irq); end
        n_vec++; if (err_count !== 8'd4) begin n_err++; $display("FAIL clr_race_count got %0d want 4", err_count); end
        step();
        mem_valid = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            step();
            drive(32'h8000_0000 + i, 4'b0000, 32'h0);
            step();
            step();
            mem_valid = 1'b0;
            if (i == 249) begin
                @(negedge clk);
                n_vec++; if (err_count !== 8'hFE) begin n_err++; $display("FAIL sat_fe got %h want fe", err_count); end
            end
        end
        @(negedge clk);
        n_vec++; if (err_count !== 8'hFF) begin n_err++; $display("FAIL sat_ff got %h want ff", err_count); end
        n_vec++; if (err_addr !== 32'h8000_012B) begin n_err++; $display("FAIL sat_eaddr got %h want 8000012b", err_addr); end
    endtask

    task automatic test_reset_mid();
        step();
        drive(32'h0200_0100, 4'b0000, 32'h0);
        s_ready = 3'b000;
        @(negedge clk);
        step();
        @(negedge clk);
        n_vec++; if (s_valid !== 3'b100) begin n_err++; $display("FAIL rm_active got %b want 100", s_valid); end
        #2;
        resetn = 1'b0;
        mem_valid = 1'b0;
        #1;
        n_vec++; if (s_valid !== 3'b000) begin n_err++; $display("FAIL rm_svalid got %b want 000", s_valid); end
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready got %b want 0", mem_ready); end
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL rm_state got %0d want 0", fsm_state); end
        n_vec++; if (err_count !== 8'h0) begin n_err++; $display("FAIL rm_count got %h want 0", err_count); end
        @(negedge clk);
        resetn = 1'b1;
        step();
        drive(32'h0000_3FFC, 4'b0000, 32'h0);
        s_ready = 3'b001;
        s_rdata[31:0] = 32'h5555_AAAA;
        @(negedge clk);
        step();
        @(negedge clk);
        n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rm_next_ready got %b want 1", mem_ready); end
        n_vec++; if (mem_rdata !== 32'h5555_AAAA) begin n_err++; $display("FAIL rm_next_rdata got %h want 5555aaaa", mem_rdata); end
        step();
        mem_valid = 1'b0; s_ready = 3'b000;
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_wait_states();
        test_write();
        test_unmapped();
        test_timeout();
        test_err_clr();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
